// File: rtl/loop_replay_fetch_if.sv
// Purpose: bundles the fetch selector's upstream (imem, uop cache, loop FSM) and downstream (decode, PC gen) signals.
// Latency: none, wires only.
// Backpressure: carries decode's stall toward the selector; no flow control of its own.
//
// Ports (slave = loop_replay_fetch view):
//   imem_instruction/imem_pc/imem_valid  in   instruction-memory stream
//   uop_instruction                      in   micro-op cache read data
//   block_signal/flush/new_pc            in   loop FSM replay request, mispredict flush and its target
//   loop_base_pc/loop_count              in   loop descriptor, sampled on replay entry
//   stall                                in   decode back-pressure
//   if_instruction/if_pc/if_valid        out  registered instruction/PC to decode
//   pc_redirect/redirect_pc              out  one-cycle PC-load strobe and its target
//   loop_iter_count                      out  saturating count of completed replay iterations
interface loop_replay_fetch_if #(
    parameter int ITER_W = 16
);
    logic [31:0]       imem_instruction;
    logic [31:0]       imem_pc;
    logic              imem_valid;
    logic [31:0]       uop_instruction;
    logic              block_signal;
    logic              flush;
    logic [31:0]       new_pc;
    logic [31:0]       loop_base_pc;
    logic [5:0]        loop_count;
    logic              stall;
    logic [31:0]       if_instruction;
    logic [31:0]       if_pc;
    logic              if_valid;
    logic              pc_redirect;
    logic [31:0]       redirect_pc;
    logic [ITER_W-1:0] loop_iter_count;

    // Upstream/downstream environment side.
    modport master (
        output imem_instruction, imem_pc, imem_valid,
        output uop_instruction,
        output block_signal, flush, new_pc,
        output loop_base_pc, loop_count,
        output stall,
        input  if_instruction, if_pc, if_valid,
        input  pc_redirect, redirect_pc,
        input  loop_iter_count
    );

    // Fetch selector side.
    modport slave (
        input  imem_instruction, imem_pc, imem_valid,
        input  uop_instruction,
        input  block_signal, flush, new_pc,
        input  loop_base_pc, loop_count,
        input  stall,
        output if_instruction, if_pc, if_valid,
        output pc_redirect, redirect_pc,
        output loop_iter_count
    );
endinterface

// File: rtl/loop_replay_fetch.sv
// Purpose: selects between the imem stream and loop replay from the uop cache, regenerating replay PCs; redirects on flush/exit.
// Latency: one cycle input-to-output (all outputs registered); replay entry adds one bubble for cache read latency.
// Backpressure: stall holds outputs, index, counter and state; flush and the one-cycle redirect pulse proceed regardless.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    loop_replay_fetch_if.slave (see interface for signal list)
module loop_replay_fetch #(
    parameter int MAX_LOOP = 32,
    parameter int ITER_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    loop_replay_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        ENTER    = 2'd1,
        REPLAY   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [5:0] MAX_LOOP_W = 6'(MAX_LOOP);

    state_t            state_q, state_n;
    logic [31:0]       base_q, base_n;
    logic [5:0]        len_q, len_n;
    logic [5:0]        idx_q, idx_n;
    logic [31:0]       instr_q, instr_n;
    logic [31:0]       pc_q, pc_n;
    logic              valid_q, valid_n;
    logic              redir_q, redir_n;
    logic [31:0]       redir_pc_q, redir_pc_n;
    logic [ITER_W-1:0] iter_q, iter_n;

    logic [5:0]        eff_cnt;
    logic [5:0]        len_m1;
    logic [31:0]       replay_pc;
    logic [31:0]       fall_through_pc;

    // Loop descriptors longer than the cache can hold are clamped.
    assign eff_cnt         = (bus.loop_count > MAX_LOOP_W) ? MAX_LOOP_W : bus.loop_count;
    assign len_m1          = len_q - 6'd1;
    assign replay_pc       = base_q + {24'd0, idx_q, 2'b00};
    assign fall_through_pc = base_q + {24'd0, len_q, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            iter_q     <= '0;
        end else begin
            state_q    <= state_n;
            base_q     <= base_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            instr_q    <= instr_n;
            pc_q       <= pc_n;
            valid_q    <= valid_n;
            redir_q    <= redir_n;
            redir_pc_q <= redir_pc_n;
            iter_q     <= iter_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        base_n     = base_q;
        len_n      = len_q;
        idx_n      = idx_q;
        instr_n    = instr_q;
        pc_n       = pc_q;
        valid_n    = valid_q;
        redir_n    = 1'b0;
        redir_pc_n = redir_pc_q;
        iter_n     = iter_q;

        if (bus.flush) begin
            // Flush overrides stall and re-arms the redirect with the newest
            // target even if one is already in flight.
            state_n    = REDIRECT;
            redir_n    = 1'b1;
            redir_pc_n = bus.new_pc;
            valid_n    = 1'b0;
            idx_n      = '0;
            len_n      = '0;
        end else if (state_q == REDIRECT) begin
            // The redirect strobe targets the PC generator, not decode, so it
            // retires after one cycle even under stall; otherwise a stalled
            // decode would turn one redirect into several PC loads.
            state_n = FETCH;
            valid_n = 1'b0;
        end else if (!bus.stall) begin
            case (state_q)
                FETCH: begin
                    instr_n = bus.imem_instruction;
                    pc_n    = bus.imem_pc;
                    valid_n = bus.imem_valid;
                    // A zero-length loop request is meaningless; stay on memory.
                    if (bus.block_signal && (eff_cnt != 6'd0)) begin
                        state_n = ENTER;
                        base_n  = bus.loop_base_pc;
                        len_n   = eff_cnt;
                        idx_n   = '0;
                    end
                end
                ENTER: begin
                    // Bubble while the cache read for index 0 completes.
                    valid_n = 1'b0;
                    state_n = REPLAY;
                end
                REPLAY: begin
                    if (!bus.block_signal) begin
                        // Exit: nothing is delivered this cycle so the redirect
                        // strobe never coincides with a valid instruction.
                        state_n    = REDIRECT;
                        redir_n    = 1'b1;
                        redir_pc_n = fall_through_pc;
                        valid_n    = 1'b0;
                    end else begin
                        instr_n = bus.uop_instruction;
                        pc_n    = replay_pc;
                        valid_n = 1'b1;
                        if (idx_q == len_m1) begin
                            idx_n = '0;
                            if (iter_q != {ITER_W{1'b1}}) begin
                                iter_n = iter_q + 1'b1;
                            end
                        end else begin
                            idx_n = idx_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    assign bus.if_instruction  = instr_q;
    assign bus.if_pc           = pc_q;
    assign bus.if_valid        = valid_q;
    assign bus.pc_redirect     = redir_q;
    assign bus.redirect_pc     = redir_pc_q;
    assign bus.loop_iter_count = iter_q;

endmodule

// File: tb/tb_loop_replay_fetch.sv
// Purpose: scoreboard bench for loop_replay_fetch; stimulus pushes expected deliveries, a negedge monitor pops and compares.
// Latency: expects one registered cycle per transfer, one bubble on replay entry.
// Backpressure: an instruction counts as delivered only on a cycle where stall is low.
module tb_loop_replay_fetch;

    typedef struct {
        bit          redir;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t q[$];
    exp_t mon_e;

    loop_replay_fetch_if #(.ITER_W(16)) bus();

    loop_replay_fetch #(.MAX_LOOP(32), .ITER_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", q.size());
        $fatal(1, "watchdog");
    end

    // Cache model: contents keyed by PC so the expected instruction is known.
    function automatic logic [31:0] uop_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_instr(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.redir = 1'b0;
        e.pc    = pc;
        e.instr = instr;
        q.push_back(e);
    endtask

    task automatic push_redir(input logic [31:0] pc);
        exp_t e;
        e.redir = 1'b1;
        e.pc    = pc;
        e.instr = '0;
        q.push_back(e);
    endtask

    // Replay one instruction at the upcoming edge, with the cache model driving the data.
    task automatic replay(input logic [31:0] pc, input bit expect_delivery);
        bus.uop_instruction = uop_of(pc);
        if (expect_delivery) push_instr(pc, uop_of(pc));
        cyc();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.pc_redirect === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL mon_redirect: got redirect to %h, required no output", bus.redirect_pc);
                end else begin
                    mon_e = q.pop_front();
                    if (!mon_e.redir || bus.redirect_pc !== mon_e.pc || bus.if_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL mon_redirect: got redirect_pc=%h if_valid=%b, required redir=%0d pc=%h if_valid=0",
                                 bus.redirect_pc, bus.if_valid, mon_e.redir, mon_e.pc);
                    end
                end
            end else if (bus.if_valid === 1'b1 && bus.stall === 1'b0) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL mon_instr: got pc=%h instr=%h, required no output", bus.if_pc, bus.if_instruction);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.redir || bus.if_pc !== mon_e.pc || bus.if_instruction !== mon_e.instr) begin
                        n_errors++;
                        $display("FAIL mon_instr: got pc=%h instr=%h, required redir=%0d pc=%h instr=%h",
                                 bus.if_pc, bus.if_instruction, mon_e.redir, mon_e.pc, mon_e.instr);
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.imem_instruction = 32'h1111_0100;
        bus.imem_pc          = 32'h100;
        bus.imem_valid       = 1'b1;
        bus.uop_instruction  = '0;
        bus.block_signal     = 1'b0;
        bus.flush            = 1'b0;
        bus.new_pc           = '0;
        bus.loop_base_pc     = '0;
        bus.loop_count       = '0;
        bus.stall            = 1'b0;
        #2 reset = 1'b0;

        // Reset with memory valid: outputs stay zero.
        cyc();
        cyc();
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_instr", bus.if_instruction, 32'd0);
        check("rst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check("rst_iter", {16'd0, bus.loop_iter_count}, 32'd0);

        // Release: first memory instruction appears one cycle later.
        reset = 1'b1;
        push_instr(32'h100, 32'h1111_0100);
        cyc();
        check("post_rst_pc", bus.if_pc, 32'h100);
        bus.imem_valid = 1'b0;
        cyc();

        // Replay entry: base 0x200, three instructions, one bubble.
        bus.block_signal = 1'b1;
        bus.loop_base_pc = 32'h200;
        bus.loop_count   = 6'd3;
        cyc();
        check("enter_valid_n", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        check("bubble_valid", {31'd0, bus.if_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            replay(32'h200 + 32'(4 * (i % 3)), 1'b1);
        end
        check("iter_after_6", {16'd0, bus.loop_iter_count}, 32'd2);

        // Exit without flush: fall-through 0x20C, single-cycle strobe.
        bus.block_signal = 1'b0;
        push_redir(32'h20C);
        cyc();
        check("exit_redirect", {31'd0, bus.pc_redirect}, 32'd1);
        check("exit_valid", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        check("exit_pulse_end", {31'd0, bus.pc_redirect}, 32'd0);

        // Stall mid-replay at 0x204 for four cycles.
        bus.block_signal = 1'b1;
        cyc();
        cyc();
        replay(32'h200, 1'b1);
        replay(32'h204, 1'b1);
        bus.stall = 1'b1;
        bus.uop_instruction = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("stall_hold_pc", bus.if_pc, 32'h204);
        end
        check("stall_hold_iter", {16'd0, bus.loop_iter_count}, 32'd2);
        bus.stall = 1'b0;
        replay(32'h208, 1'b1);
        check("post_stall_pc", bus.if_pc, 32'h208);

        // Flush raised while stalled still redirects; the held 0x200 is dropped.
        replay(32'h200, 1'b0);
        bus.stall = 1'b1;
        cyc();
        check("stall2_hold_pc", bus.if_pc, 32'h200);
        bus.flush  = 1'b1;
        bus.new_pc = 32'h400;
        push_redir(32'h400);
        cyc();
        bus.flush = 1'b0;
        check("stall_flush_redir", {31'd0, bus.pc_redirect}, 32'd1);
        check("stall_flush_pc", bus.redirect_pc, 32'h400);
        check("stall_flush_iter", {16'd0, bus.loop_iter_count}, 32'd3);
        bus.block_signal = 1'b0;
        cyc();
        check("stall_flush_end", {31'd0, bus.pc_redirect}, 32'd0);
        bus.stall = 1'b0;

        // Flush during unstalled replay.
        bus.block_signal = 1'b1;
        cyc();
        cyc();
        replay(32'h200, 1'b1);
        bus.flush  = 1'b1;
        bus.new_pc = 32'h400;
        push_redir(32'h400);
        cyc();
        check("flush_valid", {31'd0, bus.if_valid}, 32'd0);
        check("flush_rpc", bus.redirect_pc, 32'h400);
        bus.flush        = 1'b0;
        bus.block_signal = 1'b0;
        cyc();
        check("flush_end", {31'd0, bus.pc_redirect}, 32'd0);

        // Back in FETCH: memory passes through.
        bus.imem_valid       = 1'b1;
        bus.imem_pc          = 32'h500;
        bus.imem_instruction = 32'hAAAA_0500;
        push_instr(32'h500, 32'hAAAA_0500);
        cyc();
        bus.imem_valid = 1'b0;
        cyc();

        // Back-to-back flush: strobe stays high, newest target wins.
        bus.flush  = 1'b1;
        bus.new_pc = 32'h600;
        push_redir(32'h600);
        cyc();
        bus.new_pc = 32'h700;
        push_redir(32'h700);
        cyc();
        check("b2b_rpc", bus.redirect_pc, 32'h700);
        bus.flush = 1'b0;
        cyc();
        check("b2b_end", {31'd0, bus.pc_redirect}, 32'd0);

        // Zero-length loop request is ignored.
        bus.block_signal     = 1'b1;
        bus.loop_count       = 6'd0;
        bus.imem_valid       = 1'b1;
        bus.imem_pc          = 32'h800;
        bus.imem_instruction = 32'hBBBB_0800;
        push_instr(32'h800, 32'hBBBB_0800);
        cyc();
        bus.imem_pc          = 32'h804;
        bus.imem_instruction = 32'hBBBB_0804;
        push_instr(32'h804, 32'hBBBB_0804);
        cyc();
        check("zero_len_pc", bus.if_pc, 32'h804);
        bus.imem_valid   = 1'b0;
        bus.block_signal = 1'b0;
        cyc();

        // Oversized loop_count clamps to 32: fall-through 0x1000 + 128.
        bus.block_signal = 1'b1;
        bus.loop_count   = 6'd40;
        bus.loop_base_pc = 32'h1000;
        cyc();
        cyc();
        replay(32'h1000, 1'b1);
        replay(32'h1004, 1'b1);
        bus.block_signal = 1'b0;
        push_redir(32'h1080);
        cyc();
        check("clamp_rpc", bus.redirect_pc, 32'h1080);
        cyc();

        // Single-instruction loop: every replay completes an iteration; counter saturates.
        bus.block_signal = 1'b1;
        bus.loop_count   = 6'd1;
        bus.loop_base_pc = 32'h2000;
        cyc();
        cyc();
        for (int i = 0; i < 65540; i++) begin
            replay(32'h2000, 1'b1);
        end
        check("iter_saturated", {16'd0, bus.loop_iter_count}, 32'h0000_FFFF);

        // Asynchronous reset mid-replay: immediate return, no redirect.
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("async_rst_iter", {16'd0, bus.loop_iter_count}, 32'd0);
        check("async_rst_pc", bus.if_pc, 32'd0);
        cyc();
        reset            = 1'b1;
        bus.block_signal = 1'b0;
        bus.imem_valid   = 1'b1;
        bus.imem_pc      = 32'h900;
        bus.imem_instruction = 32'hCCCC_0900;
        push_instr(32'h900, 32'hCCCC_0900);
        cyc();
        check("post_async_redirect", {31'd0, bus.pc_redirect}, 32'd0);
        check("post_async_pc", bus.if_pc, 32'h900);
        bus.imem_valid = 1'b0;
        cyc();
        cyc();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
